// File: rtl/ahb_pio_pkg.sv
// rtl/ahb_pio_pkg.sv - shared encodings for the AHB-Lite PIO responder
// Purpose: AHB htrans/hsize encodings, PIO register offsets (haddr[4:2]),
//          and the bus-side FSM state type.
// Ports:   none (package)
package ahb_pio_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] OFF_LED     = 3'd0;
    localparam logic [2:0] OFF_RGB     = 3'd1;
    localparam logic [2:0] OFF_PB_DATA = 3'd2;
    localparam logic [2:0] OFF_PB_EDGE = 3'd3;
    localparam logic [2:0] OFF_PB_MASK = 3'd4;
    localparam logic [2:0] OFF_SYS_ID  = 3'd5;
    localparam logic [2:0] OFF_BLD_ID  = 3'd6;
    localparam logic [2:0] OFF_RSVD    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_state_t;

endpackage

// File: rtl/pio_pb_sync.sv
// rtl/pio_pb_sync.sv - push-button synchronizer and rising-edge detector
// Purpose: brings PB_W asynchronous buttons into the clk domain through two
//          flops, keeps a delayed copy and flags 0->1 transitions.
// Ports:   clk, rst_n   clock / async active-low reset
//          pb    [in]   raw asynchronous buttons
//          sync  [out]  second synchronizer stage
//          rise  [out]  one-cycle pulse per rising edge of sync
module pio_pb_sync #(
    parameter int PB_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PB_W-1:0] pb,
    output logic [PB_W-1:0] sync,
    output logic [PB_W-1:0] rise
);

    logic [PB_W-1:0] meta;
    logic [PB_W-1:0] sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            sync   <= '0;
            sync_d <= '0;
        end else begin
            meta   <= pb;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/ahb_pio_slave.sv
// rtl/ahb_pio_slave.sv - AHB-Lite responder for LEDs, RGB LEDs, buttons and ID words
// Purpose: zero-wait-state word access to the PIO register file; two-cycle
//          ERROR response for non-word or misaligned accesses.
// Ports:   clk, rst_n                        clock / async active-low reset
//          hsel, haddr, htrans, hwrite,
//          hsize, hready_in, hwdata  [in]    AHB-Lite responder inputs
//          hreadyout, hrdata, hresp  [out]   AHB-Lite responder outputs
//          led_o, rgb_o              [out]   LED / RGB LED registers
//          pb_i                      [in]    raw push buttons
//          irq_o                     [out]   level interrupt, |(PB_EDGE & PB_MASK)
//          sys_id_i, bld_id_i        [in]    static ID words
import ahb_pio_pkg::*;

module ahb_pio_slave #(
    parameter int LED_W = 2,
    parameter int RGB_W = 12,
    parameter int PB_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsel,
    input  logic [31:0]      haddr,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic             hready_in,
    input  logic [31:0]      hwdata,
    output logic             hreadyout,
    output logic [31:0]      hrdata,
    output logic             hresp,
    output logic [LED_W-1:0] led_o,
    output logic [RGB_W-1:0] rgb_o,
    input  logic [PB_W-1:0]  pb_i,
    output logic             irq_o,
    input  logic [31:0]      sys_id_i,
    input  logic [31:0]      bld_id_i
);

    ahb_state_t      state;
    ahb_state_t      state_next;
    logic [2:0]      off_q;
    logic            write_q;
    logic            accept;
    logic            legal;
    logic            wr_en;
    logic [PB_W-1:0] pb_sync;
    logic [PB_W-1:0] pb_rise;
    logic [PB_W-1:0] pb_edge;
    logic [PB_W-1:0] pb_mask;
    logic [PB_W-1:0] w1c_mask;
    logic            unused_bits;

    assign unused_bits = &{1'b0, haddr[31:5], htrans[0], hwdata};

    // ERR1 drives hreadyout low, so the bus cannot present a new address then.
    assign accept = hsel & htrans[1] & hready_in & (state != ST_ERR1);
    assign legal  = (hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        case (state)
            ST_ERR1: begin
                hreadyout  = 1'b0;
                hresp      = 1'b1;
                state_next = ST_ERR2;
            end
            default: begin
                if (state == ST_ERR2) begin
                    hresp = 1'b1;
                end
                if (accept) begin
                    state_next = legal ? ST_DATA : ST_ERR1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q   <= 3'd0;
            write_q <= 1'b0;
        end else if (accept) begin
            off_q   <= haddr[4:2];
            write_q <= hwrite;
        end
    end

    // Writes commit at the end of the DATA cycle, so a read in the very next
    // data phase already sees the new value.
    assign wr_en    = (state == ST_DATA) && write_q;
    assign w1c_mask = (wr_en && (off_q == OFF_PB_EDGE)) ? hwdata[PB_W-1:0] : '0;

    pio_pb_sync #(
        .PB_W (PB_W)
    ) u_pb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pb    (pb_i),
        .sync  (pb_sync),
        .rise  (pb_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_o   <= '0;
            rgb_o   <= '0;
            pb_mask <= '0;
            pb_edge <= '0;
            irq_o   <= 1'b0;
        end else begin
            if (wr_en && (off_q == OFF_LED)) begin
                led_o <= hwdata[LED_W-1:0];
            end
            if (wr_en && (off_q == OFF_RGB)) begin
                rgb_o <= hwdata[RGB_W-1:0];
            end
            if (wr_en && (off_q == OFF_PB_MASK)) begin
                pb_mask <= hwdata[PB_W-1:0];
            end
            // OR-ing the rise in after the clear lets a new edge beat a
            // same-cycle W1C of that bit.
            pb_edge <= (pb_edge & ~w1c_mask) | pb_rise;
            irq_o   <= |(pb_edge & pb_mask);
        end
    end

    always_comb begin
        hrdata = '0;
        if ((state == ST_DATA) && !write_q) begin
            case (off_q)
                OFF_LED:     hrdata = 32'(led_o);
                OFF_RGB:     hrdata = 32'(rgb_o);
                OFF_PB_DATA: hrdata = 32'(pb_sync);
                OFF_PB_EDGE: hrdata = 32'(pb_edge);
                OFF_PB_MASK: hrdata = 32'(pb_mask);
                OFF_SYS_ID:  hrdata = sys_id_i;
                OFF_BLD_ID:  hrdata = bld_id_i;
                default:     hrdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_pio_slave.sv
// tb/tb_ahb_pio_slave.sv - self-checking bench for ahb_pio_slave
module tb_ahb_pio_slave;

    localparam int LED_W = 2;
    localparam int RGB_W = 12;
    localparam int PB_W  = 4;

    localparam int K_IDLE = 0;
    localparam int K_DATA = 1;
    localparam int K_ERR1 = 2;
    localparam int K_ERR2 = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hsel = 1'b0;
    logic [31:0]      haddr = '0;
    logic [1:0]       htrans = '0;
    logic             hwrite = 1'b0;
    logic [2:0]       hsize = 3'd2;
    logic             hready_in = 1'b1;
    logic [31:0]      hwdata = '0;
    logic             hreadyout;
    logic [31:0]      hrdata;
    logic             hresp;
    logic [LED_W-1:0] led_o;
    logic [RGB_W-1:0] rgb_o;
    logic [PB_W-1:0]  pb_i = '0;
    logic             irq_o;
    logic [31:0]      sys_id_i = 32'hA5A5_0001;
    logic [31:0]      bld_id_i = 32'h0BAD_BEEF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_pio_slave #(
        .LED_W (LED_W),
        .RGB_W (RGB_W),
        .PB_W  (PB_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hready_in (hready_in),
        .hwdata    (hwdata),
        .hreadyout (hreadyout),
        .hrdata    (hrdata),
        .hresp     (hresp),
        .led_o     (led_o),
        .rgb_o     (rgb_o),
        .pb_i      (pb_i),
        .irq_o     (irq_o),
        .sys_id_i  (sys_id_i),
        .bld_id_i  (bld_id_i)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [4:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: register contents, pending data phase, button history
    logic [LED_W-1:0] m_led;
    logic [RGB_W-1:0] m_rgb;
    logic [PB_W-1:0]  m_mask;
    logic [PB_W-1:0]  m_edge;
    logic             m_irq;
    int               m_kind;
    logic             m_wr;
    logic [2:0]       m_off;
    logic [PB_W-1:0]  pbh [3];   // pbh[k] = pb_i sampled k+1 edges ago

    logic             rdy1, resp1, rdy2, resp2;
    logic [31:0]      rd;
    logic             exp_rdy, exp_resp;
    logic [31:0]      exp_rd;
    logic [2:0]       r_off;
    logic [1:0]       r_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = '0;
        hsize  = 3'd2;
    endtask

    task automatic addr_phase(input logic wr, input logic [4:0] addr, input logic [2:0] size);
        hsel      = 1'b1;
        htrans    = 2'b10;
        hwrite    = wr;
        haddr     = {27'h0, addr};
        hsize     = size;
        hready_in = 1'b1;
    endtask

    // One isolated transfer; for an ERROR response also samples the second cycle.
    task automatic xfer(input logic wr, input logic [4:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, output logic o_rdy1, output logic o_resp1,
                        output logic [31:0] o_rd, output logic o_rdy2, output logic o_resp2);
        addr_phase(wr, addr, size);
        tick();
        idle_bus();
        hwdata = wd;
        #1;
        o_rdy1  = hreadyout;
        o_resp1 = hresp;
        o_rd    = hrdata;
        o_rdy2  = 1'b1;
        o_resp2 = 1'b0;
        if (!o_rdy1) begin
            hready_in = 1'b0;
            tick();
            hready_in = 1'b1;
            #1;
            o_rdy2  = hreadyout;
            o_resp2 = hresp;
        end
        tick();
    endtask

    function automatic vec_t mk(input string n, input logic wr, input logic [4:0] a,
                                input logic [2:0] s, input logic [31:0] wd,
                                input logic e, input logic [31:0] r);
        vec_t v;
        v.name = n; v.wr = wr; v.addr = a; v.size = s;
        v.wdata = wd; v.exp_err = e; v.exp_rdata = r;
        return v;
    endfunction

    function automatic logic [31:0] mval(input logic [2:0] o);
        case (o)
            3'd0:    return 32'(m_led);
            3'd1:    return 32'(m_rgb);
            3'd2:    return 32'(pbh[1]);
            3'd3:    return 32'(m_edge);
            3'd4:    return 32'(m_mask);
            3'd5:    return sys_id_i;
            3'd6:    return bld_id_i;
            default: return 32'h0;
        endcase
    endfunction

    // Applies the register-file rules for one clock edge using the inputs present at it.
    task automatic model_edge();
        logic            acc;
        logic            lg;
        logic            irq_n;
        logic [PB_W-1:0] w1c;
        acc   = hsel && htrans[1] && hready_in;
        lg    = (hsize == 3'd2) && (haddr[1:0] == 2'b00);
        w1c   = '0;
        irq_n = |(m_edge & m_mask);
        if (m_kind == K_DATA && m_wr) begin
            case (m_off)
                3'd0:    m_led  = hwdata[LED_W-1:0];
                3'd1:    m_rgb  = hwdata[RGB_W-1:0];
                3'd3:    w1c    = hwdata[PB_W-1:0];
                3'd4:    m_mask = hwdata[PB_W-1:0];
                default: ;
            endcase
        end
        m_edge = (m_edge & ~w1c) | (pbh[1] & ~pbh[2]);
        m_irq  = irq_n;
        pbh[2] = pbh[1];
        pbh[1] = pbh[0];
        pbh[0] = pb_i;
        if (m_kind == K_ERR1) begin
            m_kind = K_ERR2;
        end else if (acc) begin
            m_kind = lg ? K_DATA : K_ERR1;
            m_wr   = hwrite;
            m_off  = haddr[4:2];
        end else begin
            m_kind = K_IDLE;
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_hreadyout", 32'(hreadyout), 32'h1);
        check("rst_hresp",     32'(hresp),     32'h0);
        check("rst_irq",       32'(irq_o),     32'h0);
        check("rst_led",       32'(led_o),     32'h0);
        check("rst_rgb",       32'(rgb_o),     32'h0);
        check("rst_hrdata",    hrdata,         32'h0);
        xfer(1'b0, 5'h14, 3'd2, 32'h0, rdy1, resp1, rd, rdy2, resp2);
        check("rst_sysid_rd",  rd,             32'hA5A5_0001);
        check("rst_sysid_ok",  32'(resp1),     32'h0);

        // ---------------- back-to-back write then read of LED ----------------
        addr_phase(1'b1, 5'h00, 3'd2);
        tick();
        hwdata = 32'h2;
        addr_phase(1'b0, 5'h00, 3'd2);
        #1;
        check("b2b_wr_rdy", 32'(hreadyout), 32'h1);
        tick();
        idle_bus();
        #1;
        check("b2b_rd_data", hrdata,     32'h2);
        check("b2b_rd_rdy",  32'(hreadyout), 32'h1);
        check("b2b_led",     32'(led_o), 32'h2);
        tick();

        // ---------------- table-driven single transfers ----------------
        vecs.push_back(mk("wr_led",     1, 5'h00, 3'd2, 32'h0000_0003, 0, 32'h0));
        vecs.push_back(mk("rd_led",     0, 5'h00, 3'd2, 32'h0,         0, 32'h3));
        vecs.push_back(mk("wr_rgb",     1, 5'h04, 3'd2, 32'hFFFF_FABC, 0, 32'h0));
        vecs.push_back(mk("rd_rgb",     0, 5'h04, 3'd2, 32'h0,         0, 32'hABC));
        vecs.push_back(mk("wr_rgb_b",   1, 5'h04, 3'd0, 32'h0000_0123, 1, 32'h0));
        vecs.push_back(mk("rd_rgb_2",   0, 5'h04, 3'd2, 32'h0,         0, 32'hABC));
        vecs.push_back(mk("rd_sysid",   0, 5'h14, 3'd2, 32'h0,         0, 32'hA5A5_0001));
        vecs.push_back(mk("rd_bldid",   0, 5'h18, 3'd2, 32'h0,         0, 32'h0BAD_BEEF));
        vecs.push_back(mk("wr_sysid",   1, 5'h14, 3'd2, 32'hFFFF_FFFF, 0, 32'h0));
        vecs.push_back(mk("rd_sysid_2", 0, 5'h14, 3'd2, 32'h0,         0, 32'hA5A5_0001));
        vecs.push_back(mk("wr_rsvd",    1, 5'h1C, 3'd2, 32'hFFFF_FFFF, 0, 32'h0));
        vecs.push_back(mk("rd_rsvd",    0, 5'h1C, 3'd2, 32'h0,         0, 32'h0));
        vecs.push_back(mk("rd_misal",   0, 5'h02, 3'd2, 32'h0,         1, 32'h0));
        vecs.push_back(mk("rd_half",    0, 5'h00, 3'd1, 32'h0,         1, 32'h0));
        vecs.push_back(mk("wr_mask",    1, 5'h10, 3'd2, 32'hFFFF_FFF5, 0, 32'h0));
        vecs.push_back(mk("rd_mask",    0, 5'h10, 3'd2, 32'h0,         0, 32'h5));
        vecs.push_back(mk("wr_mask_0",  1, 5'h10, 3'd2, 32'h0,         0, 32'h0));
        vecs.push_back(mk("rd_pbdata",  0, 5'h08, 3'd2, 32'h0,         0, 32'h0));
        vecs.push_back(mk("wr_led_2",   1, 5'h00, 3'd2, 32'hFFFF_FFFE, 0, 32'h0));
        vecs.push_back(mk("rd_led_2",   0, 5'h00, 3'd2, 32'h0,         0, 32'h2));
        foreach (vecs[i]) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                 rdy1, resp1, rd, rdy2, resp2);
            check({vecs[i].name, "_rdy"},   32'(rdy1),  32'(!vecs[i].exp_err));
            check({vecs[i].name, "_resp"},  32'(resp1), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_rdata"}, rd,         vecs[i].exp_rdata);
            if (vecs[i].exp_err) begin
                check({vecs[i].name, "_err2_rdy"},  32'(rdy2),  32'h1);
                check({vecs[i].name, "_err2_resp"}, 32'(resp2), 32'h1);
            end
        end
        check("tbl_rgb_o", 32'(rgb_o), 32'hABC);
        check("tbl_led_o", 32'(led_o), 32'h2);

        // ---------------- interrupt ----------------
        xfer(1'b1, 5'h10, 3'd2, 32'h1, rdy1, resp1, rd, rdy2, resp2);
        pb_i = 4'b0001;
        repeat (3) tick();
        check("irq_before", 32'(irq_o), 32'h0);
        tick();
        check("irq_set", 32'(irq_o), 32'h1);
        xfer(1'b0, 5'h0C, 3'd2, 32'h0, rdy1, resp1, rd, rdy2, resp2);
        check("irq_edge_rd", rd, 32'h1);
        xfer(1'b1, 5'h0C, 3'd2, 32'h1, rdy1, resp1, rd, rdy2, resp2);
        tick();
        check("irq_cleared", 32'(irq_o), 32'h0);
        xfer(1'b0, 5'h0C, 3'd2, 32'h0, rdy1, resp1, rd, rdy2, resp2);
        check("irq_edge_clr", rd, 32'h0);

        // ---------------- W1C colliding with a new rise ----------------
        pb_i = 4'b0101;
        tick();
        addr_phase(1'b1, 5'h0C, 3'd2);
        tick();
        idle_bus();
        hwdata = 32'h4;
        tick();
        xfer(1'b0, 5'h0C, 3'd2, 32'h0, rdy1, resp1, rd, rdy2, resp2);
        check("setclr_edge", rd, 32'h4);

        // ---------------- reset during a write data phase ----------------
        addr_phase(1'b1, 5'h04, 3'd2);
        tick();
        idle_bus();
        hwdata = 32'h0000_0FFF;
        #1 rst_n = 1'b0;
        #1;
        check("mrst_rgb_async", 32'(rgb_o),     32'h0);
        check("mrst_rdy",       32'(hreadyout), 32'h1);
        check("mrst_resp",      32'(hresp),     32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("mrst_rgb_after", 32'(rgb_o), 32'h0);
        check("mrst_hrdata",    hrdata,     32'h0);
        xfer(1'b0, 5'h04, 3'd2, 32'h0, rdy1, resp1, rd, rdy2, resp2);
        check("mrst_rgb_rd",    rd,         32'h0);
        check("mrst_rd_ok",     32'(resp1), 32'h0);

        // ---------------- randomized traffic against the model ----------------
        rst_n    = 1'b0;
        pb_i     = '0;
        sys_id_i = $urandom;
        bld_id_i = $urandom;
        idle_bus();
        tick();
        rst_n  = 1'b1;
        m_led  = '0; m_rgb = '0; m_mask = '0; m_edge = '0; m_irq = 1'b0;
        m_kind = K_IDLE; m_wr = 1'b0; m_off = 3'd0;
        pbh[0] = '0; pbh[1] = '0; pbh[2] = '0;
        for (int c = 0; c < 1500; c++) begin
            exp_rdy  = (m_kind != K_ERR1);
            exp_resp = (m_kind == K_ERR1) || (m_kind == K_ERR2);
            exp_rd   = (m_kind == K_DATA && !m_wr) ? mval(m_off) : 32'h0;
            hsel      = ($urandom_range(0, 3) != 0);
            htrans    = 2'($urandom);
            hwrite    = 1'($urandom);
            r_off     = 3'($urandom);
            r_lo      = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            haddr     = ($urandom & 32'hFFFF_FFE0) | {27'h0, r_off, r_lo};
            hsize     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            hready_in = exp_rdy;
            hwdata    = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                pb_i = 4'($urandom);
            end
            #1;
            check("rnd_rdy",    32'(hreadyout), 32'(exp_rdy));
            check("rnd_resp",   32'(hresp),     32'(exp_resp));
            check("rnd_hrdata", hrdata,         exp_rd);
            check("rnd_irq",    32'(irq_o),     32'(m_irq));
            check("rnd_led",    32'(led_o),     32'(m_led));
            check("rnd_rgb",    32'(rgb_o),     32'(m_rgb));
            @(posedge clk);
            model_edge();
            #1;
        end
        idle_bus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
